// File: rtl/pipelined_controller_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALU encodings and the
// control payloads carried through the pipeline registers.
package pipelined_controller_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Operation class handed from the main decoder to the ALU decoder
    typedef enum logic [2:0] {
        OPC_ADD,
        OPC_SUB,
        OPC_AND,
        OPC_OR,
        OPC_SLT,
        OPC_RTYPE
    } op_class_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic regdst;
        logic alusrc;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

endpackage

// File: rtl/pipelined_controller_if.sv
// Controller <-> datapath/hazard-unit signal bundle.
interface pipelined_controller_if #(
    parameter int unsigned ALUCTRL_W = 3
);
    logic [31:0]          InstrD;
    logic                 EqualD;
    logic                 FlushE;
    logic                 PCSrcD;
    logic                 sign_extend;
    logic                 BranchD;
    logic                 IllegalD;
    logic                 RegWriteE;
    logic                 MemtoRegE;
    logic                 RegDstE;
    logic                 ALUSrcE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic                 RegWriteM;
    logic                 MemtoRegM;
    logic                 MemWriteM;
    logic                 RegWriteW;
    logic                 MemtoRegW;

    modport master (
        output InstrD, EqualD, FlushE,
        input  PCSrcD, sign_extend, BranchD, IllegalD,
        input  RegWriteE, MemtoRegE, RegDstE, ALUSrcE, ALUControlE,
        input  RegWriteM, MemtoRegM, MemWriteM,
        input  RegWriteW, MemtoRegW
    );

    modport slave (
        input  InstrD, EqualD, FlushE,
        output PCSrcD, sign_extend, BranchD, IllegalD,
        output RegWriteE, MemtoRegE, RegDstE, ALUSrcE, ALUControlE,
        output RegWriteM, MemtoRegM, MemWriteM,
        output RegWriteW, MemtoRegW
    );
endinterface

// File: rtl/pipelined_controller_alu_decoder.sv
// ALU decoder: maps the operation class (and funct for R-type) to an ALU
// control code; flags R-type functs we do not implement.
module pipelined_controller_alu_decoder
    import pipelined_controller_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  op_class_e            op_class,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] alu_control_c,
    output logic                 illegal_funct_c
);

    always_comb begin
        alu_control_c   = ALUCTRL_W'(ALU_ADD);
        illegal_funct_c = 1'b0;
        case (op_class)
            OPC_ADD: alu_control_c = ALUCTRL_W'(ALU_ADD);
            OPC_SUB: alu_control_c = ALUCTRL_W'(ALU_SUB);
            OPC_AND: alu_control_c = ALUCTRL_W'(ALU_AND);
            OPC_OR:  alu_control_c = ALUCTRL_W'(ALU_OR);
            OPC_SLT: alu_control_c = ALUCTRL_W'(ALU_SLT);
            OPC_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_control_c = ALUCTRL_W'(ALU_ADD);
                    FUNCT_SUB: alu_control_c = ALUCTRL_W'(ALU_SUB);
                    FUNCT_AND: alu_control_c = ALUCTRL_W'(ALU_AND);
                    FUNCT_OR:  alu_control_c = ALUCTRL_W'(ALU_OR);
                    FUNCT_SLT: alu_control_c = ALUCTRL_W'(ALU_SLT);
                    default:   illegal_funct_c = 1'b1;
                endcase
            end
            default: alu_control_c = ALUCTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/pipelined_controller.sv
// MIPS 5-stage pipeline control unit: decodes InstrD, resolves branches and
// carries control bits through the D->E->M->W pipeline registers.
module pipelined_controller
    import pipelined_controller_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          HAS_BNE   = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_controller_if.slave bus
);

    logic [OP_W-1:0]      opcode;
    logic [FUNCT_W-1:0]   funct;
    op_class_e            op_class;
    ctrl_e_t              dec;
    logic                 rtype;
    logic                 is_beq;
    logic                 is_bne;
    logic                 illegal_op;
    logic                 sign_ext;
    logic [ALUCTRL_W-1:0] alu_c;
    logic                 illegal_funct;

    ctrl_e_t              e_d, e_q;
    logic [ALUCTRL_W-1:0] alu_e_d, alu_e_q;
    ctrl_m_t              m_d, m_q;
    ctrl_w_t              w_d, w_q;

    assign opcode = bus.InstrD[31:26];
    assign funct  = bus.InstrD[5:0];

    // Main decoder; R-type write enables are resolved below once funct is checked
    always_comb begin
        dec        = '0;
        op_class   = OPC_ADD;
        rtype      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        illegal_op = 1'b0;
        sign_ext   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (bus.InstrD != NOP_INSTR) begin
                    rtype    = 1'b1;
                    op_class = OPC_RTYPE;
                end
            end
            OP_LW: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                sign_ext     = 1'b1;
            end
            OP_SW: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                sign_ext     = 1'b1;
            end
            OP_BEQ: begin
                is_beq   = 1'b1;
                op_class = OPC_SUB;
                sign_ext = 1'b1;
            end
            OP_BNE: begin
                if (HAS_BNE) begin
                    is_bne   = 1'b1;
                    op_class = OPC_SUB;
                    sign_ext = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            OP_ADDI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                sign_ext     = 1'b1;
            end
            OP_SLTI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                op_class     = OPC_SLT;
                sign_ext     = 1'b1;
            end
            OP_ANDI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                op_class     = OPC_AND;
            end
            OP_ORI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                op_class     = OPC_OR;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    pipelined_controller_alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .op_class        (op_class),
        .funct           (funct),
        .alu_control_c   (alu_c),
        .illegal_funct_c (illegal_funct)
    );

    assign bus.PCSrcD      = (is_beq & bus.EqualD) | (is_bne & ~bus.EqualD);
    assign bus.BranchD     = is_beq | is_bne;
    assign bus.sign_extend = sign_ext;
    assign bus.IllegalD    = illegal_op | (rtype & illegal_funct);

    // D->E load value; a flush injects a bubble
    always_comb begin
        e_d     = '0;
        alu_e_d = ALUCTRL_W'(ALU_ADD);
        if (!bus.FlushE) begin
            e_d          = dec;
            e_d.regwrite = dec.regwrite | (rtype & ~illegal_funct);
            e_d.regdst   = rtype & ~illegal_funct;
            alu_e_d      = alu_c;
        end
    end

    always_comb begin
        m_d          = '0;
        m_d.regwrite = e_q.regwrite;
        m_d.memtoreg = e_q.memtoreg;
        m_d.memwrite = e_q.memwrite;
        w_d          = '0;
        w_d.regwrite = m_q.regwrite;
        w_d.memtoreg = m_q.memtoreg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q     <= '0;
            alu_e_q <= ALUCTRL_W'(ALU_ADD);
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            e_q     <= e_d;
            alu_e_q <= alu_e_d;
            m_q     <= m_d;
            w_q     <= w_d;
        end
    end

    assign bus.RegWriteE   = e_q.regwrite;
    assign bus.MemtoRegE   = e_q.memtoreg;
    assign bus.RegDstE     = e_q.regdst;
    assign bus.ALUSrcE     = e_q.alusrc;
    assign bus.ALUControlE = alu_e_q;
    assign bus.RegWriteM   = m_q.regwrite;
    assign bus.MemtoRegM   = m_q.memtoreg;
    assign bus.MemWriteM   = m_q.memwrite;
    assign bus.RegWriteW   = w_q.regwrite;
    assign bus.MemtoRegW   = w_q.memtoreg;

endmodule

// File: tb/tb_pipelined_controller.sv
// Self-checking bench for pipelined_controller: directed scenarios followed by
// random instruction streams compared against a mnemonic-level reference model.
module tb_pipelined_controller;

    typedef struct packed {
        logic       rw;
        logic       m2r;
        logic       mw;
        logic       rdst;
        logic       asrc;
        logic [2:0] alu;
        logic       br;
        logic       sext;
        logic       ill;
        logic       beq;
        logic       bne;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    exp_t exp_e;
    logic exp_m_rw, exp_m_m2r, exp_m_mw;
    logic exp_w_rw, exp_w_m2r;

    pipelined_controller_if #(.ALUCTRL_W(3)) bus ();

    pipelined_controller #(
        .ALUCTRL_W (3),
        .HAS_BNE   (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference decode by mnemonic
    function automatic exp_t ref_decode(input logic [31:0] instr);
        exp_t       x;
        logic [5:0] op;
        logic [5:0] fn;
        op    = instr[31:26];
        fn    = instr[5:0];
        x     = '0;
        x.alu = 3'b010;
        if (instr == 32'h0) return x;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   x.alu = 3'b010;
                    6'h22:   x.alu = 3'b110;
                    6'h24:   x.alu = 3'b000;
                    6'h25:   x.alu = 3'b001;
                    6'h2A:   x.alu = 3'b111;
                    default: x.ill = 1'b1;
                endcase
                x.rw   = ~x.ill;
                x.rdst = ~x.ill;
            end
            6'h23: begin x.rw = 1; x.asrc = 1; x.m2r = 1; x.sext = 1; end
            6'h2B: begin x.mw = 1; x.asrc = 1; x.sext = 1; end
            6'h04: begin x.br = 1; x.alu = 3'b110; x.sext = 1; x.beq = 1; end
            6'h05: begin x.br = 1; x.alu = 3'b110; x.sext = 1; x.bne = 1; end
            6'h08: begin x.rw = 1; x.asrc = 1; x.sext = 1; end
            6'h0A: begin x.rw = 1; x.asrc = 1; x.sext = 1; x.alu = 3'b111; end
            6'h0C: begin x.rw = 1; x.asrc = 1; x.alu = 3'b000; end
            6'h0D: begin x.rw = 1; x.asrc = 1; x.alu = 3'b001; end
            default: x.ill = 1'b1;
        endcase
        return x;
    endfunction

    function automatic exp_t bubble();
        exp_t x;
        x     = '0;
        x.alu = 3'b010;
        return x;
    endfunction

    // One clock: drive inputs, check decode-stage outputs, advance the model, check E/M/W
    task automatic cycle(input logic [31:0] instr, input logic eq, input logic fl, input logic rst_n);
        exp_t d;
        @(negedge clk);
        bus.InstrD = instr;
        bus.EqualD = eq;
        bus.FlushE = fl;
        reset      = rst_n;
        #1;
        d = ref_decode(instr);
        check("PCSrcD",      32'(bus.PCSrcD),      32'((d.beq & eq) | (d.bne & ~eq)));
        check("sign_extend", 32'(bus.sign_extend), 32'(d.sext));
        check("BranchD",     32'(bus.BranchD),     32'(d.br));
        check("IllegalD",    32'(bus.IllegalD),    32'(d.ill));
        @(posedge clk);
        if (!rst_n) begin
            exp_w_rw  = 1'b0; exp_w_m2r = 1'b0;
            exp_m_rw  = 1'b0; exp_m_m2r = 1'b0; exp_m_mw = 1'b0;
            exp_e     = bubble();
        end else begin
            exp_w_rw  = exp_m_rw;  exp_w_m2r = exp_m_m2r;
            exp_m_rw  = exp_e.rw;  exp_m_m2r = exp_e.m2r; exp_m_mw = exp_e.mw;
            exp_e     = fl ? bubble() : d;
        end
        #1;
        check("RegWriteE",   32'(bus.RegWriteE),   32'(exp_e.rw));
        check("MemtoRegE",   32'(bus.MemtoRegE),   32'(exp_e.m2r));
        check("RegDstE",     32'(bus.RegDstE),     32'(exp_e.rdst));
        check("ALUSrcE",     32'(bus.ALUSrcE),     32'(exp_e.asrc));
        check("ALUControlE", 32'(bus.ALUControlE), 32'(exp_e.alu));
        check("RegWriteM",   32'(bus.RegWriteM),   32'(exp_m_rw));
        check("MemtoRegM",   32'(bus.MemtoRegM),   32'(exp_m_m2r));
        check("MemWriteM",   32'(bus.MemWriteM),   32'(exp_m_mw));
        check("RegWriteW",   32'(bus.RegWriteW),   32'(exp_w_rw));
        check("MemtoRegW",   32'(bus.MemtoRegW),   32'(exp_w_m2r));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fns [5];
        int unsigned k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        r   = $urandom();
        k   = $urandom_range(0, 11);
        case (k)
            0:  return {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
            1:  return {6'h00, r[25:0]};
            2:  return {6'h23, r[25:0]};
            3:  return {6'h2B, r[25:0]};
            4:  return {6'h04, r[25:0]};
            5:  return {6'h05, r[25:0]};
            6:  return {6'h08, r[25:0]};
            7:  return {6'h0A, r[25:0]};
            8:  return {6'h0C, r[25:0]};
            9:  return {6'h0D, r[25:0]};
            10: return 32'h0;
            default: return r;
        endcase
    endfunction

    localparam logic [31:0] I_ADD   = 32'h0109_5020;
    localparam logic [31:0] I_LW    = 32'h8E08_0004;
    localparam logic [31:0] I_SW    = 32'hAE08_0008;
    localparam logic [31:0] I_BEQ   = 32'h1109_0003;
    localparam logic [31:0] I_BNE   = 32'h1509_0003;
    localparam logic [31:0] I_ORI   = 32'h3509_FFFF;
    localparam logic [31:0] I_SLTI  = 32'h2909_0005;
    localparam logic [31:0] I_BADOP = 32'hFC00_0000;
    localparam logic [31:0] I_BADFN = 32'h0109_503F;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_e      = bubble();
        exp_m_rw   = 1'b0; exp_m_m2r = 1'b0; exp_m_mw = 1'b0;
        exp_w_rw   = 1'b0; exp_w_m2r = 1'b0;
        reset      = 1'b0;
        bus.InstrD = 32'h0;
        bus.EqualD = 1'b0;
        bus.FlushE = 1'b0;

        // Reset held with an add in Decode, then released
        cycle(I_ADD, 1'b0, 1'b0, 1'b0);
        cycle(I_ADD, 1'b0, 1'b0, 1'b0);
        check("reset_alu_e", 32'(bus.ALUControlE), 32'h2);
        cycle(I_ADD, 1'b0, 1'b0, 1'b1);
        check("release_regwrite_e", 32'(bus.RegWriteE), 32'h1);

        // lw walking through E/M/W
        cycle(I_LW, 1'b0, 1'b0, 1'b1);
        check("lw_alusrc_e", 32'(bus.ALUSrcE), 32'h1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check("lw_memtoreg_m", 32'(bus.MemtoRegM), 32'h1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check("lw_memtoreg_w", 32'(bus.MemtoRegW), 32'h1);

        // Branch resolution
        cycle(I_BEQ, 1'b1, 1'b0, 1'b1);
        cycle(I_BNE, 1'b1, 1'b0, 1'b1);
        cycle(I_BNE, 1'b0, 1'b0, 1'b1);
        cycle(I_BEQ, 1'b1, 1'b1, 1'b1);

        // sw squashed by a flush on the same edge
        cycle(I_SW, 1'b0, 1'b1, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check("sw_flushed_memwrite_m", 32'(bus.MemWriteM), 32'h0);
        cycle(I_SW, 1'b0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check("sw_memwrite_m", 32'(bus.MemWriteM), 32'h1);

        // Zero- vs sign-extended immediates
        cycle(I_ORI, 1'b0, 1'b0, 1'b1);
        check("ori_alu_e", 32'(bus.ALUControlE), 32'h1);
        cycle(I_SLTI, 1'b0, 1'b0, 1'b1);
        check("slti_alu_e", 32'(bus.ALUControlE), 32'h7);

        // Illegal encodings and NOP
        cycle(I_BADOP, 1'b0, 1'b0, 1'b1);
        cycle(I_BADFN, 1'b0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);

        // Reset asserted mid-stream discards in-flight instructions
        cycle(I_LW, 1'b0, 1'b0, 1'b1);
        cycle(I_LW, 1'b0, 1'b0, 1'b0);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        check("reset_discard_memtoreg_m", 32'(bus.MemtoRegM), 32'h0);

        // Random instruction stream with random flushes and occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(rand_instr(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
